// File: rtl/fp_pkg.sv
// Shared constants for the FP multiply output stage: exponent limits, infinity pattern, flag bit positions.
package fp_pkg;
  localparam logic [8:0]  FP_EXP_BIAS = 9'd127;
  localparam logic [8:0]  FP_EXP_MAX  = 9'd254;
  localparam logic [8:0]  FP_EXP_NEG  = 9'd384;
  localparam logic [31:0] FP_INF_POS  = 32'h7F800000;
  localparam int          FP_FLAG_OVF = 1;
  localparam int          FP_FLAG_UNF = 0;
endpackage

// File: rtl/fp_mul_out_fifo.sv
// First-word-fall-through FIFO; head visible the cycle after push, 0-cycle pop.
// Push while full is dropped (sticky drop_err) unless a pop frees the slot the same cycle.
module fp_mul_out_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic                           valid,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign valid = !empty;
  // When drained, the output keeps showing the last entry that left.
  assign dout  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) drop_err <= 1'b1;
    end
  end
endmodule

// File: rtl/fp_mul_pipeline4.sv
// Final FP-multiply stage: packs sign/significand/exponent into IEEE-754 single into an output FIFO.
// Latency 1 cycle; stall_o throttles issue so the in-flight results always fit in the FIFO.
module fp_mul_pipeline4
  import fp_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int INFLIGHT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                x3,
  input  logic [8:0]                 base_ei,
  input  logic                       enable,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_data_o,
  output logic [1:0]                 out_flags_o,
  output logic                       stall_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_err_o
);
  logic        sgn;
  logic        hid;
  logic [22:0] man;
  logic [8:0]  exp_b;
  logic [31:0] pack_data;
  logic [1:0]  pack_flags;
  logic [33:0] fifo_dout;
  logic        unused_bits;

  assign sgn         = x3[31];
  assign hid         = x3[23];
  assign man         = x3[22:0];
  assign exp_b       = base_ei;
  assign unused_bits = ^x3[30:24];

  // Exponents at or above FP_EXP_NEG are wrapped negatives, hence underflow.
  always_comb begin
    pack_data  = {sgn, 31'h0};
    pack_flags = 2'b00;
    if (!hid) begin
      pack_data = {sgn, 31'h0};
    end else if (exp_b == 9'd0 || exp_b >= FP_EXP_NEG) begin
      pack_flags[FP_FLAG_UNF] = 1'b1;
    end else if (exp_b > FP_EXP_MAX) begin
      pack_data               = {sgn, FP_INF_POS[30:0]};
      pack_flags[FP_FLAG_OVF] = 1'b1;
    end else begin
      pack_data = {sgn, exp_b[7:0], man};
    end
  end

  fp_mul_out_fifo #(
    .WIDTH (34),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enable),
    .din      ({pack_flags, pack_data}),
    .pop      (out_ready_i),
    .valid    (out_valid_o),
    .dout     (fifo_dout),
    .count    (count_o),
    .drop_err (drop_err_o)
  );

  assign out_data_o  = fifo_dout[31:0];
  assign out_flags_o = fifo_dout[33:32];
  assign stall_o     = (32'(count_o) + INFLIGHT) > DEPTH;
endmodule

// File: tb/tb_fp_mul_pipeline4.sv
// Directed-vector bench for fp_mul_pipeline4 with immediate-assertion checks.
module tb_fp_mul_pipeline4;
  logic        clk;
  logic        rst;
  logic [31:0] x3;
  logic [8:0]  base_ei;
  logic        enable;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [1:0]  out_flags_o;
  logic        stall_o;
  logic [3:0]  count_o;
  logic        drop_err_o;

  int checks   = 0;
  int failures = 0;

  fp_mul_pipeline4 dut (
    .clk         (clk),
    .rst         (rst),
    .x3          (x3),
    .base_ei     (base_ei),
    .enable      (enable),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_flags_o (out_flags_o),
    .stall_o     (stall_o),
    .count_o     (count_o),
    .drop_err_o  (drop_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready=1: push one vector, check the head, then check it drained.
  task automatic single(input string tag, input logic [31:0] xv, input logic [8:0] ev,
                        input logic [31:0] exp_d, input logic [1:0] exp_f);
    x3 = xv; base_ei = ev; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_data"},  64'(out_data_o),  64'(exp_d));
    chk({tag, "_flags"}, 64'(out_flags_o), 64'(exp_f));
    @(negedge clk);
    chk({tag, "_drained"}, 64'(count_o), 64'd0);
  endtask

  initial begin
    rst = 1'b0; x3 = '0; base_ei = '0; enable = 1'b0; out_ready_i = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_data",  64'(out_data_o),  64'd0);
    chk("rst_flags", 64'(out_flags_o), 64'd0);
    chk("rst_count", 64'(count_o),     64'd0);
    chk("rst_stall", 64'(stall_o),     64'd0);
    chk("rst_drop",  64'(drop_err_o),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready_i = 1'b1;

    // Packing cases
    single("norm129",  32'h00C00000, 9'd129,   32'h40C00000, 2'b00);
    single("ovf255",   32'h00800000, 9'd255,   32'h7F800000, 2'b10);
    single("ovf383",   32'h80800000, 9'd383,   32'hFF800000, 2'b10);
    single("unf1F0",   32'h80800000, 9'h1F0,   32'h80000000, 2'b01);
    single("unf384",   32'h00800000, 9'd384,   32'h00000000, 2'b01);
    single("unf0",     32'h00800000, 9'd0,     32'h00000000, 2'b01);
    single("zero",     32'h00000000, 9'd0,     32'h00000000, 2'b00);
    single("zero_pri", 32'h80000000, 9'd255,   32'h80000000, 2'b00);
    single("norm254",  32'h00800000, 9'd254,   32'h7F000000, 2'b00);
    single("norm1",    32'h80FFFFFF, 9'd1,     32'h80FFFFFF, 2'b00);

    // Fill, overflow, drain
    out_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      x3 = 32'h00800000 | 32'(i); base_ei = 9'd100; enable = 1'b1;
      @(negedge clk);
      chk($sformatf("fill_count%0d", i), 64'(count_o), 64'(i));
      chk($sformatf("fill_stall%0d", i), 64'(stall_o), 64'(i >= 4));
    end
    chk("fill_drop_clear", 64'(drop_err_o), 64'd0);
    x3 = 32'h00800009;
    @(negedge clk);
    enable = 1'b0;
    chk("ovr_drop",  64'(drop_err_o), 64'd1);
    chk("ovr_count", 64'(count_o),    64'd8);
    chk("ovr_head",  64'(out_data_o), 64'h32000001);
    out_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_valid%0d", k), 64'(out_valid_o), 64'd1);
      chk($sformatf("drain_data%0d", k),  64'(out_data_o),  64'(32'h32000000 | 32'(k)));
      chk($sformatf("drain_count%0d", k), 64'(count_o),     64'(9 - k));
      chk($sformatf("drain_stall%0d", k), 64'(stall_o),     64'((9 - k) >= 4));
      @(negedge clk);
    end
    chk("empty_valid", 64'(out_valid_o), 64'd0);
    chk("empty_hold",  64'(out_data_o),  64'h32000008);
    chk("drop_sticky", 64'(drop_err_o),  64'd1);

    // Asynchronous reset mid-cycle with entries queued
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x3 = 32'h00800000 | 32'(i + 16); base_ei = 9'd50; enable = 1'b1;
      @(negedge clk);
    end
    enable = 1'b0;
    chk("q3_count", 64'(count_o), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_count", 64'(count_o),     64'd0);
    chk("arst_stall", 64'(stall_o),     64'd0);
    chk("arst_drop",  64'(drop_err_o),  64'd0);
    chk("arst_data",  64'(out_data_o),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    x3 = 32'h00C00000; base_ei = 9'd129; enable = 1'b1;
    chk("post_pre_valid", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    enable = 1'b0;
    chk("post_valid", 64'(out_valid_o), 64'd1);
    chk("post_data",  64'(out_data_o),  64'h40C00000);
    chk("post_count", 64'(count_o),     64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
